// File: rtl/stage_req_sequencer.sv
// Clocked four-phase req/ack sequencer: decodes a RISC-V major opcode and walks
// the stage requests in class order, with per-phase timeout abort.
module stage_req_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set,
  input  logic [6:0]       opcode,
  input  logic             ack1,
  input  logic             ack2,
  input  logic             ack3,
  input  logic             ack4,
  output logic             req1,
  output logic             req2_1,
  output logic             req2_2,
  output logic             req3,
  output logic             req4,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] retired
);

  localparam int PW = $clog2(TIMEOUT);
  localparam logic [PW-1:0] TO_LAST = PW'(TIMEOUT - 1);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [3:0] {
    IDLE, REQ1, REL1, REQ21, REL21, REQ22, REL22,
    REQ3, REL3, REQ4, REL4, DONE, ERR
  } state_t;

  state_t          state_reg, state_next;
  logic [PW-1:0]   phase_cnt_reg;
  logic [6:0]      op_reg;
  logic [1:0]      code_next;
  logic [3:0]      ack_in, ack_s;
  logic            to_hit;

  assign ack_in = {ack4, ack3, ack2, ack1};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sync
      logic [SYNC_STAGES-1:0] sync_reg;
      if (SYNC_STAGES == 1) begin : g_one
        always_ff @(posedge clk) begin
          if (reset) sync_reg <= '0;
          else       sync_reg <= ack_in[gi];
        end
      end else begin : g_multi
        always_ff @(posedge clk) begin
          if (reset) sync_reg <= '0;
          else       sync_reg <= {sync_reg[SYNC_STAGES-2:0], ack_in[gi]};
        end
      end
      assign ack_s[gi] = sync_reg[SYNC_STAGES-1];
    end
  endgenerate

  assign to_hit = (phase_cnt_reg == TO_LAST);

  // Each REQ waits for its ack high, each REL for it low; the stage after a
  // release depends on the instruction class latched at set.
  always_comb begin
    state_next = state_reg;
    code_next  = 2'b00;
    case (state_reg)
      IDLE: begin
        if (set) begin
          case (opcode)
            OP_R, OP_LOAD, OP_STORE, OP_BRANCH: state_next = REQ1;
            default: begin
              state_next = ERR;
              code_next  = 2'b01;
            end
          endcase
        end
      end
      REQ1:  state_next = ack_s[0] ? REL1  : (to_hit ? ERR : REQ1);
      REL1:  state_next = !ack_s[0] ? ((op_reg == OP_BRANCH) ? REQ22 : REQ21)
                                    : (to_hit ? ERR : REL1);
      REQ21: state_next = ack_s[1] ? REL21 : (to_hit ? ERR : REQ21);
      REL21: state_next = !ack_s[1] ? ((op_reg == OP_R) ? REQ4 : REQ3)
                                    : (to_hit ? ERR : REL21);
      REQ22: state_next = ack_s[1] ? REL22 : (to_hit ? ERR : REQ22);
      REL22: state_next = !ack_s[1] ? DONE : (to_hit ? ERR : REL22);
      REQ3:  state_next = ack_s[2] ? REL3  : (to_hit ? ERR : REQ3);
      REL3:  state_next = !ack_s[2] ? ((op_reg == OP_LOAD) ? REQ4 : DONE)
                                    : (to_hit ? ERR : REL3);
      REQ4:  state_next = ack_s[3] ? REL4  : (to_hit ? ERR : REQ4);
      REL4:  state_next = !ack_s[3] ? DONE : (to_hit ? ERR : REL4);
      DONE:  state_next = IDLE;
      ERR:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (state_next == ERR && state_reg != IDLE) code_next = 2'b10;
  end

  // Outputs are decoded from the next state so they change on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      phase_cnt_reg <= '0;
      op_reg        <= '0;
      req1          <= 1'b0;
      req2_1        <= 1'b0;
      req2_2        <= 1'b0;
      req3          <= 1'b0;
      req4          <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      err_code      <= 2'b00;
      retired       <= '0;
    end else begin
      state_reg     <= state_next;
      phase_cnt_reg <= (state_next != state_reg || state_reg == IDLE) ? '0
                                                                        : phase_cnt_reg + 1'b1;
      req1          <= (state_next == REQ1);
      req2_1        <= (state_next == REQ21);
      req2_2        <= (state_next == REQ22);
      req3          <= (state_next == REQ3);
      req4          <= (state_next == REQ4);
      busy          <= (state_next != IDLE);
      done          <= (state_next == DONE);
      err           <= (state_next == ERR);
      if (state_reg == IDLE && set) begin
        op_reg   <= opcode;
        err_code <= 2'b00;
      end
      if (state_next == ERR)  err_code <= code_next;
      if (state_next == DONE) retired  <= retired + 1'b1;
    end
  end

endmodule

// File: tb/tb_stage_req_sequencer.sv
// Directed bench for stage_req_sequencer: auto-responding stage units, a
// request-order monitor, and hand-computed expectations per step.
module tb_stage_req_sequencer;

  localparam int CW = 4;
  localparam int TO = 64;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic          clk = 1'b0;
  logic          reset, set;
  logic [6:0]    opcode;
  logic [3:0]    ackv = 4'b0000;
  logic          ack1, ack2, ack3, ack4;
  logic          req1, req2_1, req2_2, req3, req4;
  logic          busy, done, err;
  logic [1:0]    err_code;
  logic [CW-1:0] retired;

  assign ack1 = ackv[0];
  assign ack2 = ackv[1];
  assign ack3 = ackv[2];
  assign ack4 = ackv[3];

  stage_req_sequencer #(.SYNC_STAGES(2), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .set(set), .opcode(opcode),
    .ack1(ack1), .ack2(ack2), .ack3(ack3), .ack4(ack4),
    .req1(req1), .req2_1(req2_1), .req2_2(req2_2), .req3(req3), .req4(req4),
    .busy(busy), .done(done), .err(err), .err_code(err_code), .retired(retired)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Stage units: raise ack two negedges after the request, drop it once req falls.
  logic en3 = 1'b1;
  int   rcnt [4];
  always @(negedge clk) begin
    logic [3:0] rq;
    rq = {req4, req3, req2_1 | req2_2, req1};
    for (int i = 0; i < 4; i++) begin
      if (rq[i]) begin
        if (!ackv[i]) begin
          rcnt[i]++;
          if (rcnt[i] >= 2 && (i != 2 || en3)) ackv[i] = 1'b1;
        end
      end else begin
        ackv[i] = 1'b0;
        rcnt[i] = 0;
      end
    end
  end

  // Order monitor: ids 1=req1 2=req2_1 3=req2_2 4=req3 5=req4.
  int         seq_q [$];
  int         done_total = 0, err_total = 0, overlap_total = 0;
  logic [4:0] prev_req = 5'b0;
  always @(negedge clk) begin
    logic [4:0] cur;
    cur = {req4, req3, req2_2, req2_1, req1};
    if ($countones(cur) > 1) overlap_total++;
    for (int i = 0; i < 5; i++)
      if (cur[i] && !prev_req[i]) seq_q.push_back(i + 1);
    prev_req = cur;
    if (done === 1'b1) done_total++;
    if (err === 1'b1) err_total++;
  end

  function automatic int seq_code(input int start);
    int c = 0;
    for (int i = start; i < seq_q.size(); i++) c = c * 16 + seq_q[i];
    return c;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_legal(input logic [6:0] op, input string tag, input int exp_seq);
    int n, s0, d0;
    n = 0;
    while (busy !== 1'b0 && n < 200) begin @(negedge clk); n++; end
    s0 = seq_q.size();
    d0 = done_total;
    opcode = op;
    set = 1'b1;
    @(negedge clk);
    set = 1'b0;
    chk({tag, "_busy_n1"}, 32'(busy), 32'(1));
    chk({tag, "_req1_n1"}, 32'(req1), 32'(1));
    n = 0;
    while (done !== 1'b1 && err !== 1'b1 && n < 500) begin @(negedge clk); n++; end
    chk({tag, "_done_seen"}, 32'(done), 32'(1));
    @(negedge clk);
    chk({tag, "_seq"}, 32'(seq_code(s0)), 32'(exp_seq));
    chk({tag, "_done_cnt"}, 32'(done_total - d0), 32'(1));
  endtask

  initial begin
    int n, e0;
    reset = 1'b1;
    set = 1'b0;
    opcode = 7'd0;
    repeat (3) @(negedge clk);
    chk("rst_reqs", 32'({req1, req2_1, req2_2, req3, req4}), 32'(0));
    chk("rst_flags", 32'({busy, done, err}), 32'(0));
    chk("rst_err_code", 32'(err_code), 32'(0));
    chk("rst_retired", 32'(retired), 32'(0));
    reset = 1'b0;
    @(negedge clk);

    // R-type: 1 -> 2_1 -> 4
    run_legal(OP_R, "rtype", 'h125);
    chk("rtype_retired", 32'(retired), 32'(1));
    chk("rtype_overlap", 32'(overlap_total), 32'(0));

    // Load, store, branch back to back
    do_reset();
    e0 = err_total;
    run_legal(OP_LOAD, "load", 'h1245);
    run_legal(OP_STORE, "store", 'h124);
    run_legal(OP_BRANCH, "branch", 'h13);
    chk("b2b_retired", 32'(retired), 32'(3));
    chk("b2b_no_err", 32'(err_total - e0), 32'(0));
    chk("b2b_overlap", 32'(overlap_total), 32'(0));

    // Illegal opcode
    do_reset();
    opcode = 7'b1111111;
    set = 1'b1;
    @(negedge clk);
    set = 1'b0;
    chk("illegal_err_n1", 32'(err), 32'(1));
    chk("illegal_busy_n1", 32'(busy), 32'(1));
    chk("illegal_code_n1", 32'(err_code), 32'(1));
    chk("illegal_reqs_n1", 32'({req1, req2_1, req2_2, req3, req4}), 32'(0));
    @(negedge clk);
    chk("illegal_err_n2", 32'(err), 32'(0));
    chk("illegal_busy_n2", 32'(busy), 32'(0));
    chk("illegal_code_held", 32'(err_code), 32'(1));
    opcode = 7'bx;
    set = 1'b1;
    @(negedge clk);
    set = 1'b0;
    chk("xop_err", 32'(err), 32'(1));
    chk("xop_req1", 32'(req1), 32'(0));
    @(negedge clk);

    // Timeout in REQ_3
    do_reset();
    en3 = 1'b0;
    opcode = OP_LOAD;
    set = 1'b1;
    @(negedge clk);
    set = 1'b0;
    n = 0;
    while (req3 !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    chk("to_req3_rose", 32'(req3), 32'(1));
    repeat (TO - 1) @(negedge clk);
    chk("to_req3_held", 32'(req3), 32'(1));
    chk("to_err_early", 32'(err), 32'(0));
    @(negedge clk);
    chk("to_req3_drop", 32'(req3), 32'(0));
    chk("to_err", 32'(err), 32'(1));
    chk("to_code", 32'(err_code), 32'(2));
    chk("to_retired", 32'(retired), 32'(0));
    en3 = 1'b1;
    @(negedge clk);
    chk("to_busy_clear", 32'(busy), 32'(0));

    // Reset while req2_1 is high, then a clean R-type
    do_reset();
    opcode = OP_R;
    set = 1'b1;
    @(negedge clk);
    set = 1'b0;
    n = 0;
    while (req2_1 !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    chk("midrst_req2_1_seen", 32'(req2_1), 32'(1));
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_reqs", 32'({req1, req2_1, req2_2, req3, req4}), 32'(0));
    chk("midrst_busy", 32'(busy), 32'(0));
    reset = 1'b0;
    @(negedge clk);
    run_legal(OP_R, "after_rst", 'h125);
    chk("after_rst_retired", 32'(retired), 32'(1));

    // Retired counter wrap at CNT_W = 4
    do_reset();
    for (int k = 1; k <= 17; k++) begin
      run_legal(OP_R, "wrap", 'h125);
      if (k >= 15) chk("wrap_retired", 32'(retired), 32'((k == 15) ? 15 : k - 16));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
